// File: rtl/if_fetch.sv
// In-order storage ring with synchronous clear; head entry is read combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push.
// No full/empty tracking: the owner pushes only with space and pops only when non-empty.
module if_fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wr_ptr] <= wdat;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  assign rdat = mem[rd_ptr];
endmodule

// Instruction fetch: issues PCs to imem, pairs responses with their PC, buffers them for ID.
// Latency: response in cycle N is presented to ID in cycle N+1.
// Backpressure: outstanding + buffered entries are capped at DEPTH; pc_ready_o drops when full or flushing.
module if_fetch #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [PC_W-1:0]   id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_fault_o,
  output logic              proto_err_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_W + INST_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   outstanding, outstanding_nxt;
  logic [CW-1:0]   drop_cnt, drop_cnt_nxt;
  logic [CW-1:0]   buf_count, buf_count_nxt;
  logic            credit;
  logic            fire;
  logic            rsp_vld;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            id_pop;
  logic [PC_W-1:0] rsp_pc;
  logic [EW-1:0]   buf_head;

  assign credit = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW+1)'(DEPTH);

  assign imem_req_valid_o = pc_valid_i & (state == RUN) & credit & ~flush_i;
  assign imem_req_addr_o  = pc_i;
  assign fire             = imem_req_valid_o & imem_req_ready_i;
  assign pc_ready_o       = fire;

  // A response landing in the flush cycle belongs to the old stream and is discarded.
  assign rsp_vld  = imem_rsp_valid_i & (outstanding != '0);
  assign rsp_drop = rsp_vld & ((drop_cnt != '0) | flush_i);
  assign rsp_keep = rsp_vld & ~rsp_drop;

  assign id_valid_o = (buf_count != '0) & ~flush_i;
  assign id_pop     = id_valid_o & id_ready_i;

  always_comb begin
    outstanding_nxt = outstanding + CW'(fire) - CW'(rsp_vld);
    buf_count_nxt   = buf_count + CW'(rsp_keep) - CW'(id_pop);
    drop_cnt_nxt    = drop_cnt;
    state_nxt       = state;
    if (flush_i) begin
      buf_count_nxt = '0;
      drop_cnt_nxt  = outstanding_nxt;
    end else if (rsp_drop) begin
      drop_cnt_nxt = drop_cnt - CW'(1);
    end
    case (state)
      RUN:     if (flush_i && (outstanding_nxt != '0)) state_nxt = FLUSH;
      FLUSH:   if (drop_cnt_nxt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      outstanding <= '0;
      drop_cnt    <= '0;
      buf_count   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      buf_count   <= buf_count_nxt;
      if (imem_rsp_valid_i && (outstanding == '0)) proto_err_o <= 1'b1;
    end
  end

  if_fetch_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_addr_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush_i),
    .push (fire),
    .wdat (pc_i),
    .pop  (rsp_keep),
    .rdat (rsp_pc)
  );

  if_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_out_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush_i),
    .push (rsp_keep),
    .wdat ({rsp_pc, imem_rsp_data_i, imem_rsp_err_i}),
    .pop  (id_pop),
    .rdat (buf_head)
  );

  assign {id_pc_o, id_inst_o, id_fault_o} = buf_head;
endmodule

// File: tb/tb_if_fetch.sv
// Random and directed stimulus for if_fetch, checked against a queue-based fetch model.
module tb_if_fetch;
  localparam int PC_W = 64, INST_W = 32, DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC_W-1:0]   pc_i;
  logic              pc_valid_i, pc_ready_o, flush_i;
  logic              imem_req_valid_o, imem_req_ready_i;
  logic [PC_W-1:0]   imem_req_addr_o;
  logic              imem_rsp_valid_i;
  logic [INST_W-1:0] imem_rsp_data_i;
  logic              imem_rsp_err_i;
  logic              id_valid_o, id_ready_i;
  logic [PC_W-1:0]   id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_fault_o, proto_err_o;

  if_fetch #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i), .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_fault_o(id_fault_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; bit drop; } fl_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; bit fault; } ent_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;

  fl_t   inflight[$];
  ent_t  outq[$];
  ent_t  seen[$];
  mreq_t memq[$];
  bit    m_proto;

  int n_tests = 0, n_fail = 0, cyc = 0, fires = 0;
  int lat_min = 1, lat_max = 1;
  bit rsp_rand = 0;
  bit k_pc_valid, k_flush, k_req_ready, k_id_ready, k_spur;
  logic [63:0] pc_gen, flush_tgt;

  function automatic logic [31:0] mem_inst(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic bit mem_err(input logic [63:0] a);
    return a[4:2] == 3'd1;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    bit exp_req, exp_fire, exp_idv, fire_dut;
    logic [63:0] fire_addr;
    int occ, lat;
    bit in_fl;
    fl_t e;
    @(negedge clk);
    pc_i = pc_gen; pc_valid_i = k_pc_valid; flush_i = k_flush;
    imem_req_ready_i = k_req_ready; id_ready_i = k_id_ready;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; imem_rsp_err_i = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc && (!rsp_rand || $urandom_range(0, 3) != 0)) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_inst(memq[0].addr);
      imem_rsp_err_i   = mem_err(memq[0].addr);
      void'(memq.pop_front());
    end else if (k_spur) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hDEAD_BEEF;
    end
    #1;
    occ      = inflight.size() + outq.size();
    in_fl    = inflight.size() > 0 && inflight[0].drop;
    exp_req  = k_pc_valid && !in_fl && occ < DEPTH && !k_flush;
    exp_fire = exp_req && k_req_ready;
    exp_idv  = outq.size() > 0 && !k_flush;
    check_eq("req_valid", 64'(imem_req_valid_o), 64'(exp_req));
    check_eq("pc_ready", 64'(pc_ready_o), 64'(exp_fire));
    if (exp_req) check_eq("req_addr", imem_req_addr_o, pc_gen);
    check_eq("id_valid", 64'(id_valid_o), 64'(exp_idv));
    if (exp_idv) begin
      check_eq("id_pc", id_pc_o, outq[0].pc);
      check_eq("id_inst", 64'(id_inst_o), 64'(outq[0].inst));
      check_eq("id_fault", 64'(id_fault_o), 64'(outq[0].fault));
    end
    check_eq("proto_err", 64'(proto_err_o), 64'(m_proto));
    if (id_valid_o && id_ready_i) seen.push_back('{id_pc_o, id_inst_o, id_fault_o});
    fire_dut  = imem_req_valid_o && imem_req_ready_i;
    fire_addr = imem_req_addr_o;
    @(posedge clk);
    cyc++;
    if (exp_idv && k_id_ready) void'(outq.pop_front());
    if (imem_rsp_valid_i) begin
      if (inflight.size() == 0) m_proto = 1'b1;
      else begin
        e = inflight.pop_front();
        if (!e.drop && !k_flush) outq.push_back('{e.pc, mem_inst(e.pc), mem_err(e.pc)});
      end
    end
    if (k_flush) begin
      outq.delete();
      foreach (inflight[i]) inflight[i].drop = 1'b1;
    end
    if (exp_fire) inflight.push_back('{pc_gen, 1'b0});
    if (fire_dut) begin
      lat = int'($urandom_range(lat_min, lat_max));
      memq.push_back('{fire_addr, cyc + lat - 1});
      fires++;
    end
    if (k_flush) pc_gen = flush_tgt;
    else if (fire_dut) pc_gen = pc_gen + 64'd4;
  endtask

  task automatic drain();
    k_pc_valid = 0; k_flush = 0; k_id_ready = 1; k_req_ready = 1; k_spur = 0;
    for (int i = 0; i < 80 && (inflight.size() + outq.size() + memq.size()) != 0; i++) step();
    check_eq("drain_empty", 64'(inflight.size() + outq.size() + memq.size()), 64'd0);
  endtask

  task automatic check_zero_outs();
    check_eq("rst_id_valid", 64'(id_valid_o), 64'd0);
    check_eq("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    check_eq("rst_pc_ready", 64'(pc_ready_o), 64'd0);
    check_eq("rst_id_pc", id_pc_o, 64'd0);
    check_eq("rst_id_inst", 64'(id_inst_o), 64'd0);
    check_eq("rst_id_fault", 64'(id_fault_o), 64'd0);
    check_eq("rst_proto", 64'(proto_err_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pc_i = '0; pc_valid_i = 0; flush_i = 0; imem_req_ready_i = 0;
    imem_rsp_valid_i = 0; imem_rsp_data_i = '0; imem_rsp_err_i = 0; id_ready_i = 0;
    k_pc_valid = 0; k_flush = 0; k_req_ready = 1; k_id_ready = 1; k_spur = 0;
    pc_gen = 64'h8000_0000; flush_tgt = '0; m_proto = 0;
    repeat (2) @(negedge clk);
    #1 check_zero_outs();
    @(negedge clk) rst = 1'b1;

    // back-to-back fetch with single-cycle memory, fault on the second word
    pc_gen = 64'h8000_0000; seen.delete(); fires = 0;
    for (int i = 0; i < 12; i++) begin
      k_pc_valid = (fires < 3);
      step();
    end
    check_eq("b2b_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      check_eq("b2b_pc", seen[i].pc, 64'h8000_0000 + 64'(4 * i));
      check_eq("b2b_inst", 64'(seen[i].inst), 64'(mem_inst(64'h8000_0000 + 64'(4 * i))));
      check_eq("b2b_fault", 64'(seen[i].fault), 64'(i == 1));
    end
    drain();

    // ID stalled: credit caps issue at DEPTH
    fires = 0; k_id_ready = 0; k_pc_valid = 1;
    repeat (10) step();
    check_eq("stall_issued", 64'(fires), 64'(DEPTH));
    #1 check_eq("stall_id_valid", 64'(id_valid_o), 64'd1);
    k_id_ready = 1;
    repeat (3) step();
    drain();

    // asynchronous reset with two requests in flight
    lat_min = 6; lat_max = 6; fires = 0;
    for (int i = 0; i < 6 && fires < 2; i++) begin
      k_pc_valid = 1;
      step();
    end
    check_eq("pre_rst_fires", 64'(fires), 64'd2);
    @(negedge clk);
    #2;
    pc_valid_i = 0; imem_rsp_valid_i = 0; flush_i = 0;
    rst = 1'b0;
    #1 check_zero_outs();
    inflight.delete(); outq.delete(); memq.delete(); m_proto = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k_pc_valid = 0;
    repeat (8) step();

    // flush with two outstanding: old responses dropped, new stream starts at target
    lat_min = 5; lat_max = 5; fires = 0; pc_gen = 64'h8000_0000;
    for (int i = 0; i < 6 && fires < 2; i++) begin
      k_pc_valid = 1;
      step();
    end
    seen.delete();
    k_flush = 1; flush_tgt = 64'h8000_0100; k_pc_valid = 1;
    step();
    k_flush = 0;
    repeat (20) step();
    check_eq("flush_seen", 64'(seen.size() > 0), 64'd1);
    if (seen.size() > 0) check_eq("flush_first_pc", seen[0].pc, 64'h8000_0100);
    drain();

    // randomized traffic
    lat_min = 1; lat_max = 4; rsp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      k_pc_valid  = $urandom_range(0, 3) != 0;
      k_req_ready = $urandom_range(0, 3) != 0;
      k_id_ready  = $urandom_range(0, 2) != 0;
      k_flush     = $urandom_range(0, 24) == 0;
      flush_tgt   = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
      step();
    end
    drain();

    // response with nothing outstanding
    rsp_rand = 0; lat_min = 1; lat_max = 1;
    k_spur = 1;
    step();
    k_spur = 0;
    repeat (3) step();
    #1;
    check_eq("proto_sticky", 64'(proto_err_o), 64'd1);
    check_eq("proto_no_entry", 64'(id_valid_o), 64'd0);
    seen.delete(); fires = 0; pc_gen = 64'h8000_0040;
    for (int i = 0; i < 6; i++) begin
      k_pc_valid = (fires < 1);
      step();
    end
    check_eq("proto_after_cnt", 64'(seen.size()), 64'd1);
    if (seen.size() > 0) check_eq("proto_after_pc", seen[0].pc, 64'h8000_0040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
